delay_meter: RTL and testbench



---
 rtl/delay_meter_pkg.sv | 14 +
 rtl/delay_meter_crossing_det.sv | 20 ++
 rtl/delay_meter.sv | 116 +++++++++++
 tb/tb_delay_meter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/delay_meter_pkg.sv
// delay_meter_pkg: FSM states, delay-line tap table and select-code decision boundaries
package delay_meter_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_REF, S_COUNT, S_ACCUM, S_DONE} state_t;
  localparam int N_TAPS = 6;
  localparam int TAPS [N_TAPS] = '{4, 8, 12, 16, 19, 23};
  localparam int SEL_BND [N_TAPS-1] = '{6, 10, 14, 17, 21};
  // Code is the number of boundaries strictly below d, so a tie lands on the lower code
  function automatic logic [2:0] sel_of(input int d);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < N_TAPS - 1; i++) s = (d > SEL_BND[i]) ? s + 3'd1 : s;
    return s;
  endfunction
endpackage

// File: rtl/delay_meter_crossing_det.sv
// crossing_det: rising threshold crossing detector with hysteresis re-arm
module crossing_det #(
  parameter int DW   = 14,
  parameter int HYST = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_thr,
  input  logic [DW-1:0] i_sample,
  output logic          o_fire
);
  logic          r_armed;
  logic [DW-1:0] w_lo;
  assign w_lo   = (i_thr >= DW'(HYST)) ? i_thr - DW'(HYST) : '0;
  assign o_fire = r_armed && (i_sample >= i_thr);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_armed <= 1'b0;
    else if (o_fire) r_armed <= 1'b0;
    else if (i_sample < w_lo) r_armed <= 1'b1;
endmodule

// File: rtl/delay_meter.sv
// delay_meter: times N ref-to-delayed threshold crossings and reports the rounded mean
// delay, the nearest delay-select code, and a timeout flag for a dead delayed path.
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int DW       = 14,
  parameter int CNT_W    = 8,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 64,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    threshold,
  input  logic [DW-1:0]    ref_data,
  input  logic [DW-1:0]    dly_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] delay_cycles,
  output logic [2:0]       sel_est,
  output logic             timeout_err
);
  localparam int SW = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  state_t              r_state;
  logic [DW-1:0]       r_ref, r_dly, r_thr;
  logic [CNT_W-1:0]    r_cnt, r_sample;
  logic [SW-1:0]       r_sum;
  logic [AVG_LOG2-1:0] r_idx;
  logic [DW-1:0]       w_thr;
  logic                w_ref_fire, w_dly_fire;
  logic [SW-1:0]       w_sum, w_rnd;
  logic [CNT_W-1:0]    w_avg;
  // Detectors follow the live threshold while idle so they are already armed at start
  assign w_thr = (r_state == S_IDLE) ? threshold : r_thr;
  assign w_sum = r_sum + SW'(r_sample);
  assign w_rnd = w_sum + SW'(2 ** (AVG_LOG2 - 1));
  assign w_avg = w_rnd[SW-1:AVG_LOG2];
  crossing_det #(.DW(DW), .HYST(HYST)) u_ref_det (
    .clk(clk), .rst(rst), .i_thr(w_thr), .i_sample(r_ref), .o_fire(w_ref_fire)
  );
  crossing_det #(.DW(DW), .HYST(HYST)) u_dly_det (
    .clk(clk), .rst(rst), .i_thr(w_thr), .i_sample(r_dly), .o_fire(w_dly_fire)
  );
  // r_cnt counts wait cycles in WAIT_REF and cycles since the ref crossing in COUNT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= S_IDLE;
      r_ref        <= '0;
      r_dly        <= '0;
      r_thr        <= '0;
      r_cnt        <= '0;
      r_sample     <= '0;
      r_sum        <= '0;
      r_idx        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      delay_cycles <= '0;
      sel_est      <= '0;
      timeout_err  <= 1'b0;
    end else begin
      r_ref <= ref_data;
      r_dly <= dly_data;
      done  <= 1'b0;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_thr       <= threshold;
            r_sum       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_WAIT_REF;
          end
        S_WAIT_REF:
          if (w_ref_fire && w_dly_fire) begin
            r_sample <= '0;
            r_state  <= S_ACCUM;
          end else if (w_ref_fire) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_COUNT;
          end else if (r_cnt == TO - CNT_W'(1)) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            r_state     <= S_DONE;
          end else r_cnt <= r_cnt + CNT_W'(1);
        S_COUNT:
          if (w_dly_fire) begin
            r_sample <= r_cnt;
            r_state  <= S_ACCUM;
          end else if (r_cnt == TO) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            r_state     <= S_DONE;
          end else r_cnt <= r_cnt + CNT_W'(1);
        S_ACCUM: begin
          r_sum <= w_sum;
          r_idx <= r_idx + AVG_LOG2'(1);
          r_cnt <= '0;
          if (&r_idx) begin
            done         <= 1'b1;
            busy         <= 1'b0;
            delay_cycles <= w_avg;
            sel_est      <= sel_of(int'(w_avg));
            r_state      <= S_DONE;
          end else r_state <= S_WAIT_REF;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_delay_meter.sv
// tb_delay_meter: scoreboard bench; a behavioural delay line feeds dly_data and a
// monitor pops the expected result on every done pulse.
module tb_delay_meter;
  import delay_meter_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [13:0] threshold = '0, ref_data = '0, dly_data = '0;
  logic        busy, done, timeout_err;
  logic [7:0]  delay_cycles;
  logic [2:0]  sel_est;
  typedef struct packed {logic [7:0] d; logic [2:0] s; logic e;} exp_t;
  exp_t        q[$];
  int          checks = 0, failures = 0, n_done = 0, n_push = 0;
  int          phase = 0, dly = 4, mode = 0;
  logic [13:0] hist [32];

  delay_meter dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .ref_data(ref_data), .dly_data(dly_data), .busy(busy), .done(done),
    .delay_cycles(delay_cycles), .sel_est(sel_est), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [13:0] wave(input int p, input int m);
    if (p < 64) return 14'd0;
    if (m == 1 && p < 84) return (p % 2 == 1) ? 14'd8232 : 14'd8152;
    return 14'd16383;
  endfunction

  // mode 0: square wave, 1: square wave with +/-40 noise after the crossing, 2: dead delayed path
  initial begin
    for (int i = 0; i < 32; i++) hist[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
      hist[0]  = ref_data;
      phase    = (phase + 1) % 128;
      ref_data = wave(phase, mode);
      dly_data = (mode == 2) ? 14'd0 : hist[dly-1];
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          check("delay_cycles", int'(delay_cycles), int'(e.d));
          check("sel_est", int'(sel_est), int'(e.s));
          check("timeout_err", int'(timeout_err), int'(e.e));
        end
      end
    end
  end

  task automatic push_exp(input int d, input int s, input int e);
    q.push_back('{d: 8'(d), s: 3'(s), e: 1'(e)});
    n_push++;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_wait no done within %0d cycles, pending=%0d", budget, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input int d_line, input int m, input int ed, input int es, input int ee);
    mode = m;
    dly  = d_line;
    repeat (200) @(posedge clk);
    push_exp(ed, es, ee);
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    wait_done(2000);
    check("busy_after_done", int'(busy), 0);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 300 && phase != p; i++) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_delay"}, int'(delay_cycles), 0);
    check({tag, "_sel"}, int'(sel_est), 0);
    check({tag, "_terr"}, int'(timeout_err), 0);
  endtask

  initial begin
    threshold = 14'd8192;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    run(TAPS[0], 0, 4, 0, 0);
    run(TAPS[5], 0, 23, 5, 0);
    run(TAPS[4], 0, 19, 4, 0);
    run(6, 0, 6, 0, 0);
    run(7, 0, 7, 1, 0);
    run(21, 0, 21, 4, 0);
    run(21, 2, 21, 4, 1);
    mode = 1;
    dly  = 4;
    repeat (200) @(posedge clk);
    push_exp(4, 0, 0);
    pulse_start();
    repeat (10) @(posedge clk);
    threshold = 14'd2000;
    pulse_start();
    wait_done(2000);
    threshold = 14'd8192;
    repeat (700) @(posedge clk);
    mode = 0;
    dly  = 23;
    repeat (200) @(posedge clk);
    wait_phase(0);
    pulse_start();
    wait_phase(80);
    #1 rst = 1'b1;
    @(negedge clk);
    check_zero("midrun_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    run(23, 0, 23, 5, 0);
    repeat (300) @(posedge clk);
    check("done_count", n_done, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
